// File: rtl/mem_seq_pkg.sv
// Shared encodings for the reg_mem command sequencer.
package mem_seq_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR       = 3'd1;
    localparam logic [2:0] ST_RD_ISSUE = 3'd2;
    localparam logic [2:0] ST_RD_WAIT  = 3'd3;
    localparam logic [2:0] ST_RSP      = 3'd4;
    localparam logic [2:0] ST_CLR      = 3'd5;

endpackage

// File: rtl/mem_seq.sv
// Command sequencer in front of reg_mem: read/write/clear commands in,
// registered memory strobes out, read data returned on a backpressured channel.
//
// state      | meaning
// -----------+---------------------------------------------------------
// IDLE       | waiting for a command, cmd_ready=1
// WR         | mem_wen=1 for one cycle, reg_mem writes at the end of it
// RD_ISSUE   | mem_addr presented, reg_mem samples it at the end of cycle
// RD_WAIT    | mem_data_out valid, captured into rsp_data
// RSP        | rsp_valid held until rsp_ready
// CLR        | zero-writes sweep addresses 0..2**ADDR_BITS-1
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_BITS  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [ADDR_BITS-1:0] CLR_LAST = '1;

    logic [2:0]           state;
    logic [ADDR_BITS-1:0] clr_cnt;

    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            clr_cnt     <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            mem_wen     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd_op)
                            OP_READ: begin
                                mem_addr <= cmd_addr;
                                mem_wen  <= 1'b0;
                                state    <= ST_RD_ISSUE;
                            end
                            OP_WRITE: begin
                                mem_addr    <= cmd_addr;
                                mem_data_in <= cmd_wdata;
                                mem_wen     <= 1'b1;
                                state       <= ST_WR;
                            end
                            OP_CLEAR: begin
                                clr_cnt     <= '0;
                                mem_addr    <= '0;
                                mem_data_in <= '0;
                                mem_wen     <= 1'b1;
                                state       <= ST_CLR;
                            end
                            default: begin
                                // reserved op is consumed with no side effects
                                state <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    mem_wen <= 1'b0;
                    state   <= ST_IDLE;
                end
                ST_RD_ISSUE: begin
                    state <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    rsp_data  <= mem_data_out;
                    rsp_valid <= 1'b1;
                    state     <= ST_RSP;
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_CLR: begin
                    if (clr_cnt == CLR_LAST) begin
                        mem_wen <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        clr_cnt  <= clr_cnt + ADDR_BITS'(1);
                        mem_addr <= clr_cnt + ADDR_BITS'(1);
                    end
                end
                default: begin
                    mem_wen   <= 1'b0;
                    rsp_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_seq.sv
// Directed bench for mem_seq driving a behavioural reg_mem.
module tb_mem_seq;
    import mem_seq_pkg::*;

    localparam int DW = 4;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AB-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic [AB-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic          mem_wen;
    logic [DW-1:0] mem_data_out;

    logic [DW-1:0] mem [2**AB];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    mem_seq #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_wen      (mem_wen),
        .mem_data_out (mem_data_out)
    );

    // reg_mem model: registered read, zero on the data port after a write
    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] <= mem_data_in;
            mem_data_out  <= '0;
        end else begin
            mem_data_out  <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // called at a negedge with the DUT idle; returns at the negedge after the accept edge
    task automatic issue(input logic [1:0] op, input logic [AB-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
    endtask

    task automatic do_write(input logic [AB-1:0] a, input logic [DW-1:0] d, input string tag);
        chk({tag, "_rdy"}, 32'(cmd_ready), 32'd1);
        issue(OP_WRITE, a, d);
        chk({tag, "_wen"}, 32'(mem_wen), 32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), 32'(a));
        chk({tag, "_din"}, 32'(mem_data_in), 32'(d));
        @(negedge clk);
        chk({tag, "_wen_off"}, 32'(mem_wen), 32'd0);
        chk({tag, "_rdy_back"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_read(input logic [AB-1:0] a, input logic [DW-1:0] exp, input string tag);
        int lat;
        rsp_ready = 1'b1;
        issue(OP_READ, a, '0);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
        @(negedge clk);
        chk({tag, "_vld_off"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic fill_f();
        for (int i = 0; i < 2**AB; i++)
            do_write(AB'(i), 4'hF, $sformatf("fill%0d", i));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_READ;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_rdy",  32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_wen",  32'(mem_wen),   32'd0);
        chk("rst_vld",  32'(rsp_valid), 32'd0);
        chk("rst_data", 32'(rsp_data),  32'd0);
        chk("rst_addr", 32'(mem_addr),  32'd0);

        do_write(3'd3, 4'hA, "wr3");
        do_read(3'd3, 4'hA, "rd3");
        do_write(3'd5, 4'h6, "wr5");
        do_read(3'd5, 4'h6, "rd5");

        // backpressure, with a write held on the command port that must not land
        rsp_ready = 1'b0;
        issue(OP_READ, 3'd3, '0);
        repeat (2) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 3'd3;
        cmd_wdata = 4'h5;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_vld", i),  32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d_data", i), 32'(rsp_data),  32'hA);
            chk($sformatf("bp%0d_rdy", i),  32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_vld_off", 32'(rsp_valid), 32'd0);
        chk("bp_rdy_back", 32'(cmd_ready), 32'd1);
        do_read(3'd3, 4'hA, "bp_reread");

        // full clear
        fill_f();
        issue(OP_CLEAR, '0, 4'h9);
        for (int i = 0; i < 2**AB; i++) begin
            chk($sformatf("clr%0d_wen", i),  32'(mem_wen),  32'd1);
            chk($sformatf("clr%0d_addr", i), 32'(mem_addr), 32'(i));
            chk($sformatf("clr%0d_din", i),  32'(mem_data_in), 32'd0);
            @(negedge clk);
        end
        chk("clr_wen_off", 32'(mem_wen),   32'd0);
        chk("clr_rdy",     32'(cmd_ready), 32'd1);
        for (int i = 0; i < 2**AB; i++)
            do_read(AB'(i), 4'h0, $sformatf("clrrd%0d", i));

        // reserved op is accepted and does nothing
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = OP_RSVD;
        cmd_addr  = 3'd2;
        cmd_wdata = 4'h7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rsv%0d_rdy", i),  32'(cmd_ready), 32'd1);
            chk($sformatf("rsv%0d_busy", i), 32'(busy),      32'd0);
            chk($sformatf("rsv%0d_wen", i),  32'(mem_wen),   32'd0);
            chk($sformatf("rsv%0d_vld", i),  32'(rsp_valid), 32'd0);
        end
        cmd_valid = 1'b0;
        do_read(3'd2, 4'h0, "rsv_rd2");

        // reset while the clear counter sits at 4
        fill_f();
        issue(OP_CLEAR, '0, '0);
        repeat (4) @(negedge clk);
        chk("mid_addr4", 32'(mem_addr), 32'd4);
        rst = 1'b1;
        #1;
        chk("mid_wen",  32'(mem_wen),   32'd0);
        chk("mid_busy", 32'(busy),      32'd0);
        chk("mid_rdy",  32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2**AB; i++)
            do_read(AB'(i), (i < 4) ? 4'h0 : 4'hF, $sformatf("midrd%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
